ringbuf_l1a_reader: RTL
=======================

// Module: ringbuf_l1a_reader
// PURPOSE
//  Read side of the DAQ ring buffer filled by the 16-channel transfer block. On each L1A,
//  captures the write pointer and streams a fixed window (NSAMP samples x 16 ch, 12 bit)
//  from the dual-port ring RAM to the downstream packer. Queues up to L1A_DEPTH pending
//  L1As and honours downstream backpressure. Sits between ring RAM port B and the packer.
// PARAMETERS
//  AW         10  ring RAM address width; depth = 2**AW words, 16 words per sample time
//  NSAMP       8  samples per event (window = NSAMP*16 words)
//  L1A_DEPTH   4  pending-L1A queue depth (power of 2)
// PORTS
//  CLK        in   1   40 MHz DAQ clock; all logic rising edge
//  RST_B      in   1   asynchronous, active-low reset
//  L1A        in   1   one-cycle trigger pulse
//  WR_ADDR    in   AW  ring buffer write pointer (next address to be written)
//  L1A_OFST   in   AW-4 trigger latency in sample times, quasi-static
//  RD_EN      out  1   RAM port B read enable
//  RD_ADDR    out  AW  RAM port B address
//  RD_DATA    in   12  RAM port B data, valid 1 cycle after RD_EN
//  DOUT       out  12  output word
//  DOUT_VLD   out  1   DOUT valid
//  DOUT_LAST  out  1   marks final word of event
//  DOUT_RDY   in   1   downstream accept; transfer when DOUT_VLD & DOUT_RDY
//  BUSY       out  1   queue non-empty or event in progress
//  L1A_OVFL   out  1   sticky: L1A arrived with queue full (L1A dropped)
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, FSM IDLE, L1A counter 0. Reset mid-event aborts at once.
//  L1A capture: start = (WR_ADDR - {L1A_OFST,4'h0}) mod 2**AW, pushed same cycle as L1A.
//  Full queue: L1A dropped, L1A_OVFL set until reset; L1A counter still increments.
//  FSM: IDLE -> (queue non-empty) pop start, load addr, cnt=0 -> [HDR] -> READ -> IDLE.
//  READ: RD_EN when 2-entry output skid buffer has room counting the in-flight read;
//   RD_ADDR increments mod 2**AW (wrap 2**AW-1 -> 0); leaves after NSAMP*16 reads issued.
//  Latency: L1A to first DOUT_VLD = 3 cycles from IDLE with DOUT_RDY=1 (no header).
//  Throughput: 1 word/cycle while DOUT_RDY=1; DOUT_RDY=0 freezes DOUT/VLD/LAST, no loss.
//  DOUT_LAST on word NSAMP*16-1 (0-based). Next event may start the cycle after last read.
//  L1A in same cycle as pop: push and pop both occur; occupancy unchanged.
//  BUSY = queue non-empty | FSM != IDLE | skid non-empty.
// CONFIGURATION
//  RINGBUF_L1A_HDR_EN defined: HDR state emits one header word {4'hA, L1A_CNT[7:0]}
//   before data, counter value captured with start address; event = NSAMP*16+1 words.
//  Undefined: no HDR state, no counter logic; event = NSAMP*16 words.
// STRUCTURE
//  dcfeb_daq_pkg: NCHAN=16, SAMP_W=12, HDR_TAG=4'hA, FSM state encoding.
//  Sub-module l1a_addr_fifo: sync FIFO (width AW[+8], depth L1A_DEPTH), full/empty flags.
// TESTING
//  1 AW=10, WR_ADDR=0x200, L1A_OFST=4, one L1A -> reads 0x1C0..0x23F, 128 words, LAST on #127.
//  2 WR_ADDR=0x010, L1A_OFST=2 -> start 0x3F0, addresses wrap 0x3FF->0x000, ends at 0x06F.
//  3 5 L1As back-to-back, DOUT_RDY=1 -> 4 events out back-to-back, L1A_OVFL=1 after 5th.
//  4 DOUT_RDY toggled randomly (50%) -> output equals RAM model sequence, no dup/drop.
//  5 RST_B low mid-event for 1 cycle -> outputs 0 async, BUSY=0, next L1A starts clean event.
//  6 RINGBUF_L1A_HDR_EN, 3rd L1A -> first word 0xA02, then 128 data words, LAST on #128.

Source files
------------

// File: rtl/ringbuf_l1a_reader_pkg.sv
// Shared constants, FSM encoding and output word type for the ring-buffer L1A reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ringbuf_l1a_reader_pkg;

  localparam int NCHAN  = 16;
  localparam int SAMP_W = 12;
  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_READ = 2'd2
  } state_t;

  // One word headed for the packer, tagged with its end-of-event marker
  typedef struct packed {
    logic              last;
    logic [SAMP_W-1:0] dat;
  } word_t;

  // Header word layout: tag nibble above the low byte of the trigger count
  function automatic logic [SAMP_W-1:0] hdr_word(input logic [7:0] cnt);
    return {HDR_TAG, cnt};
  endfunction

endpackage

// File: rtl/ringbuf_l1a_addr_fifo.sv
// Synchronous FIFO of pending L1A entries (start address, optionally trigger count).
// Latency: pushed entry visible at head_dat the cycle after push.
// Backpressure: push ignored while full, pop ignored while empty; caller watches flags.
module l1a_addr_fifo
  import ringbuf_l1a_reader_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  // Pointer and occupancy update; simultaneous push and pop leaves the count unchanged
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    cnt_d    = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // Storage array needs no reset: entries are only read once counted in
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ringbuf_l1a_reader.sv
// Ring-buffer read side: per L1A, stream NSAMP*16 words from RAM port B to the packer.
// Latency: L1A to first DOUT_VLD is 3 cycles from idle (2 to the header word with RINGBUF_L1A_HDR_EN).
// Backpressure: DOUT_RDY low holds DOUT/DOUT_VLD/DOUT_LAST; RAM reads pause so the 2-entry skid never overflows.
module ringbuf_l1a_reader
  import ringbuf_l1a_reader_pkg::*;
#(
  parameter int AW        = 10,
  parameter int NSAMP     = 8,
  parameter int L1A_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_B,
  input  logic              L1A,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [AW-5:0]     L1A_OFST,
  output logic              RD_EN,
  output logic [AW-1:0]     RD_ADDR,
  input  logic [SAMP_W-1:0] RD_DATA,
  output logic [SAMP_W-1:0] DOUT,
  output logic              DOUT_VLD,
  output logic              DOUT_LAST,
  input  logic              DOUT_RDY,
  output logic              BUSY,
  output logic              L1A_OVFL
);

  localparam int NWORDS = NSAMP * NCHAN;
  localparam int CW     = $clog2(NWORDS);
`ifdef RINGBUF_L1A_HDR_EN
  localparam int QW = AW + 8;
`else
  localparam int QW = AW;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  word_t         out_q, out_d;
  word_t         sk_q, sk_d;
  logic          out_vld_q, out_vld_d;
  logic          sk_vld_q, sk_vld_d;
  logic          ovfl_q, ovfl_d;

  logic [AW-1:0] cap_start;
  logic [QW-1:0] q_push_dat, q_head;
  logic          q_push, q_pop, q_full, q_empty;
  logic          pop_out, room, rd_en, last_rd, wr_vld;
  logic [2:0]    occ_after;
  word_t         wr_word;

`ifdef RINGBUF_L1A_HDR_EN
  logic [7:0] l1a_cnt_q, l1a_cnt_d;
  logic [7:0] hdr_cnt_q, hdr_cnt_d;
  logic       hdr_wr;
`endif

  // Window start: trigger latency is counted in whole sample times (16 words each)
  assign cap_start = WR_ADDR - {L1A_OFST, 4'h0};
  assign q_push    = L1A && !q_full;
`ifdef RINGBUF_L1A_HDR_EN
  assign q_push_dat = {l1a_cnt_q, cap_start};
`else
  assign q_push_dat = cap_start;
`endif

  // The event being read keeps its queue slot until its last read issues
  l1a_addr_fifo #(
    .W     (QW),
    .DEPTH (L1A_DEPTH)
  ) u_l1a_fifo (
    .clk      (CLK),
    .rst_n    (RST_B),
    .push     (q_push),
    .push_dat (q_push_dat),
    .pop      (q_pop),
    .head_dat (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Skid room: occupancy next cycle must leave a slot for a read issued now
  always_comb begin
    pop_out   = out_vld_q && DOUT_RDY;
    occ_after = 3'(out_vld_q) + 3'(sk_vld_q) + 3'(rd_vld_q) - 3'(pop_out);
    room      = (occ_after < 3'd2);
    rd_en     = (state_q == ST_READ) && room;
    last_rd   = (cnt_q == CW'(NWORDS - 1));
  end

  // Event sequencing: pick up a queued start, optionally emit header, then issue the reads
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    q_pop     = 1'b0;
    rd_vld_d  = rd_en;
    rd_last_d = rd_en && last_rd;
`ifdef RINGBUF_L1A_HDR_EN
    hdr_cnt_d = hdr_cnt_q;
    hdr_wr    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          addr_d = q_head[AW-1:0];
          cnt_d  = '0;
`ifdef RINGBUF_L1A_HDR_EN
          hdr_cnt_d = q_head[QW-1:AW];
          state_d   = ST_HDR;
`else
          state_d = ST_READ;
`endif
        end
      end
`ifdef RINGBUF_L1A_HDR_EN
      ST_HDR: begin
        if (room) begin
          hdr_wr  = 1'b1;
          state_d = ST_READ;
        end
      end
`endif
      ST_READ: begin
        if (rd_en) begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q + CW'(1);
          if (last_rd) begin
            q_pop   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word entering the skid: RAM data, or the header (never on the same cycle as data)
  always_comb begin
    wr_word.last = rd_last_q;
    wr_word.dat  = RD_DATA;
    wr_vld       = rd_vld_q;
`ifdef RINGBUF_L1A_HDR_EN
    if (hdr_wr) begin
      wr_word.last = 1'b0;
      wr_word.dat  = hdr_word(hdr_cnt_q);
      wr_vld       = 1'b1;
    end
`endif
  end

  // Two-entry skid: out_q drives the port, sk_q catches the word that lands during a stall
  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    sk_d      = sk_q;
    sk_vld_d  = sk_vld_q;
    if (!out_vld_q || pop_out) begin
      if (sk_vld_q) begin
        out_d     = sk_q;
        out_vld_d = 1'b1;
        sk_vld_d  = wr_vld;
        if (wr_vld) sk_d = wr_word;
      end else begin
        out_vld_d = wr_vld;
        if (wr_vld) out_d = wr_word;
      end
    end else if (wr_vld) begin
      sk_d     = wr_word;
      sk_vld_d = 1'b1;
    end
  end

  // Dropped L1As are remembered until reset; the trigger count advances regardless
  always_comb begin
    ovfl_d = ovfl_q || (L1A && q_full);
`ifdef RINGBUF_L1A_HDR_EN
    l1a_cnt_d = l1a_cnt_q + 8'(L1A);
`endif
  end

  // State registers; reset aborts any event in progress immediately
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      out_q     <= '0;
      sk_q      <= '0;
      out_vld_q <= 1'b0;
      sk_vld_q  <= 1'b0;
      ovfl_q    <= 1'b0;
`ifdef RINGBUF_L1A_HDR_EN
      l1a_cnt_q <= '0;
      hdr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      out_q     <= out_d;
      sk_q      <= sk_d;
      out_vld_q <= out_vld_d;
      sk_vld_q  <= sk_vld_d;
      ovfl_q    <= ovfl_d;
`ifdef RINGBUF_L1A_HDR_EN
      l1a_cnt_q <= l1a_cnt_d;
      hdr_cnt_q <= hdr_cnt_d;
`endif
    end
  end

  // A read in flight with an empty skid still counts as busy
  assign RD_EN     = rd_en;
  assign RD_ADDR   = addr_q;
  assign DOUT      = out_q.dat;
  assign DOUT_VLD  = out_vld_q;
  assign DOUT_LAST = out_vld_q && out_q.last;
  assign BUSY      = !q_empty || (state_q != ST_IDLE) || out_vld_q || sk_vld_q || rd_vld_q;
  assign L1A_OVFL  = ovfl_q;

endmodule
